// File: rtl/normalize_round.sv
// Normalize/round stage for the FP adder: applies the control FSM's shift and
// exponent strobes to the held sum, rounds to nearest-even, and flags exponent limits.
module normalize_round #(
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            Load,
  input  logic [MANTISSABITS+1:0]         SumIn,
  input  logic [EXPBITS-1:0]              ExpIn,
  input  logic                            GuardIn,
  input  logic                            RoundIn,
  input  logic                            StickyIn,
  input  logic                            SREn,
  input  logic                            SLEn,
  input  logic                            NoShift,
  input  logic [$clog2(MANTISSABITS)-1:0] ShiftAmount,
  input  logic                            IncrEn,
  input  logic                            DecrEn,
  input  logic                            SelExpMuxR,
  input  logic                            SelManMuxR,
  output logic [MANTISSABITS+1:0]         Out,
  output logic [EXPBITS-1:0]              ExpOut,
  output logic [MANTISSABITS-1:0]         ResultMan,
  output logic                            ResultValid,
  output logic                            Overflow,
  output logic                            Underflow
);

  localparam int MW = MANTISSABITS + 2;
  localparam int SW = $clog2(MANTISSABITS);
  localparam int XW = MW + 3;
  localparam logic [MW-1:0]      HIDDEN  = {2'b01, {MANTISSABITS{1'b0}}};
  localparam logic [EXPBITS-1:0] EXP_MAX = {EXPBITS{1'b1}};

  // Round-to-nearest-even; a carry out of the hidden bit stays in the MSB for the FSM.
  function automatic logic [MW-1:0] f_round_rne(input logic [MW-1:0] m,
                                                input logic g, input logic r,
                                                input logic s);
    logic inc;
    inc = g & (r | s | m[0]);
    return m + {{(MW-1){1'b0}}, inc};
  endfunction

  // Returns {overflow, exponent}; saturates at all-ones.
  function automatic logic [EXPBITS:0] f_exp_inc(input logic [EXPBITS-1:0] e);
    logic [EXPBITS:0] s;
    s = {1'b0, e} + {{EXPBITS{1'b0}}, 1'b1};
    if (s >= {1'b0, EXP_MAX})
      return {1'b1, EXP_MAX};
    return s;
  endfunction

  // Returns {underflow, exponent}; clamps at zero when the shift reaches the exponent.
  function automatic logic [EXPBITS:0] f_exp_dec(input logic [EXPBITS-1:0] e,
                                                 input logic [SW-1:0] sh);
    logic signed [EXPBITS+1:0] d;
    d = $signed({2'b00, e}) - $signed({{(EXPBITS+2-SW){1'b0}}, sh});
    if (d[EXPBITS+1] || (d == '0))
      return {1'b1, {EXPBITS{1'b0}}};
    return {1'b0, d[EXPBITS-1:0]};
  endfunction

  logic [MW-1:0]      r_man_p1;
  logic [EXPBITS-1:0] r_exp_p1;
  logic [2:0]         r_grs_p1;
  logic               r_vld_p1;
  logic               r_ovf_p1;
  logic               r_unf_p1;

  logic [MW-1:0]      w_man_p0;
  logic [EXPBITS-1:0] w_exp_p0;
  logic [2:0]         w_grs_p0;
  logic               w_vld_p0;
  logic               w_ovf_p0;
  logic               w_unf_p0;
  logic               w_op_p0;
  logic [XW-1:0]      w_shl;
  logic [MW-1:0]      w_m;
  logic               w_g;
  logic               w_r;
  logic               w_s;
  logic [EXPBITS:0]   w_einc;
  logic [EXPBITS:0]   w_edec;
  logic               w_hold_exp;

  assign w_shl      = {r_man_p1, r_grs_p1} << ShiftAmount;
  assign w_einc     = f_exp_inc(r_exp_p1);
  assign w_edec     = f_exp_dec(r_exp_p1, ShiftAmount);
  assign w_hold_exp = IncrEn & DecrEn;

  always_comb begin
    w_man_p0 = r_man_p1;
    w_exp_p0 = r_exp_p1;
    w_grs_p0 = r_grs_p1;
    w_ovf_p0 = r_ovf_p1;
    w_unf_p0 = r_unf_p1;
    w_op_p0  = 1'b0;
    w_m      = r_man_p1;
    w_g      = r_grs_p1[2];
    w_r      = r_grs_p1[1];
    w_s      = r_grs_p1[0];

    if (Load) begin
      w_man_p0 = SumIn;
      w_exp_p0 = ExpIn;
      w_grs_p0 = {GuardIn, RoundIn, StickyIn};
      w_ovf_p0 = 1'b0;
      w_unf_p0 = 1'b0;
    end else if (SREn && SelManMuxR) begin
      // Post-round renormalize: the dropped LSB is zero after a rounding carry.
      w_op_p0  = 1'b1;
      w_man_p0 = r_man_p1 >> 1;
      w_grs_p0 = 3'b000;
      if (IncrEn && SelExpMuxR && !w_hold_exp) begin
        w_exp_p0 = w_einc[EXPBITS-1:0];
        if (w_einc[EXPBITS]) begin
          w_ovf_p0 = 1'b1;
          w_man_p0 = HIDDEN;
        end
      end
    end else if (SREn) begin
      w_op_p0  = 1'b1;
      w_m      = r_man_p1 >> 1;
      w_g      = r_man_p1[0];
      w_r      = r_grs_p1[2];
      w_s      = r_grs_p1[1] | r_grs_p1[0];
      w_man_p0 = f_round_rne(w_m, w_g, w_r, w_s);
      w_grs_p0 = 3'b000;
      if (IncrEn && !w_hold_exp) begin
        w_exp_p0 = w_einc[EXPBITS-1:0];
        if (w_einc[EXPBITS]) begin
          w_ovf_p0 = 1'b1;
          w_man_p0 = HIDDEN;
        end
      end
    end else if (SLEn) begin
      w_op_p0  = 1'b1;
      w_m      = w_shl[XW-1:3];
      w_g      = w_shl[2];
      w_r      = w_shl[1];
      w_s      = w_shl[0];
      w_man_p0 = f_round_rne(w_m, w_g, w_r, w_s);
      w_grs_p0 = 3'b000;
      if (DecrEn && !w_hold_exp) begin
        w_exp_p0 = w_edec[EXPBITS-1:0];
        if (w_edec[EXPBITS])
          w_unf_p0 = 1'b1;
      end
    end else if (NoShift) begin
      w_op_p0  = 1'b1;
      w_man_p0 = f_round_rne(r_man_p1, r_grs_p1[2], r_grs_p1[1], r_grs_p1[0]);
      w_grs_p0 = 3'b000;
    end

    w_vld_p0 = w_op_p0 & ~w_man_p0[MW-1];
  end

  // Stage p0 -> p1: single registered stage, result visible one cycle after the op.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_man_p1 <= '0;
      r_exp_p1 <= '0;
      r_grs_p1 <= '0;
      r_vld_p1 <= 1'b0;
      r_ovf_p1 <= 1'b0;
      r_unf_p1 <= 1'b0;
    end else begin
      r_man_p1 <= w_man_p0;
      r_exp_p1 <= w_exp_p0;
      r_grs_p1 <= w_grs_p0;
      r_vld_p1 <= w_vld_p0;
      r_ovf_p1 <= w_ovf_p0;
      r_unf_p1 <= w_unf_p0;
    end
  end

  assign Out         = r_man_p1;
  assign ExpOut      = r_exp_p1;
  assign ResultMan   = r_man_p1[MANTISSABITS-1:0];
  assign ResultValid = r_vld_p1;
  assign Overflow    = r_ovf_p1;
  assign Underflow   = r_unf_p1;

endmodule

// File: tb/tb_normalize_round.sv
// Bench for normalize_round: vector table of load+operation pairs plus hand-written
// sequences, expected results queued at drive time and compared after each clock edge.
module tb_normalize_round;

  logic        Clock = 1'b0;
  logic        Reset, Load;
  logic [24:0] SumIn;
  logic [7:0]  ExpIn;
  logic        GuardIn, RoundIn, StickyIn;
  logic        SREn, SLEn, NoShift;
  logic [4:0]  ShiftAmount;
  logic        IncrEn, DecrEn, SelExpMuxR, SelManMuxR;
  logic [24:0] Out;
  logic [7:0]  ExpOut;
  logic [22:0] ResultMan;
  logic        ResultValid, Overflow, Underflow;

  normalize_round #(.EXPBITS(8), .MANTISSABITS(23)) dut (
    .Clock(Clock), .Reset(Reset), .Load(Load), .SumIn(SumIn), .ExpIn(ExpIn),
    .GuardIn(GuardIn), .RoundIn(RoundIn), .StickyIn(StickyIn),
    .SREn(SREn), .SLEn(SLEn), .NoShift(NoShift), .ShiftAmount(ShiftAmount),
    .IncrEn(IncrEn), .DecrEn(DecrEn), .SelExpMuxR(SelExpMuxR), .SelManMuxR(SelManMuxR),
    .Out(Out), .ExpOut(ExpOut), .ResultMan(ResultMan), .ResultValid(ResultValid),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [24:0] out;
    logic [7:0]  ex;
    logic        vld, ovf, unf;
  } exp_t;

  // op: 1 SREn, 2 SLEn, 3 NoShift, 4 renorm (SREn+SelManMuxR), 5 SREn+SLEn
  typedef struct {
    logic [24:0] sum;
    logic [7:0]  ex;
    logic [2:0]  grs;
    int          op;
    logic [4:0]  sh;
    logic        inc, dec, sele;
    logic [24:0] e_out;
    logic [7:0]  e_ex;
    logic        e_vld, e_ovf, e_unf;
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic [24:0] sum, logic [7:0] ex, logic [2:0] grs, int op,
                              logic [4:0] sh, logic inc, logic dec, logic sele,
                              logic [24:0] e_out, logic [7:0] e_ex,
                              logic e_vld, logic e_ovf, logic e_unf);
    vec_t v;
    v.sum = sum; v.ex = ex; v.grs = grs; v.op = op; v.sh = sh;
    v.inc = inc; v.dec = dec; v.sele = sele;
    v.e_out = e_out; v.e_ex = e_ex; v.e_vld = e_vld; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  function automatic exp_t mke(logic [24:0] o, logic [7:0] e, logic v, logic ov, logic un);
    exp_t x;
    x.out = o; x.ex = e; x.vld = v; x.ovf = ov; x.unf = un;
    return x;
  endfunction

  task automatic chk(input string tag, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s %s: got %0h expected %0h", tag, field, act, req);
    end
  endtask

  task automatic idle_inputs();
    Load = 0; SumIn = '0; ExpIn = '0; GuardIn = 0; RoundIn = 0; StickyIn = 0;
    SREn = 0; SLEn = 0; NoShift = 0; ShiftAmount = '0;
    IncrEn = 0; DecrEn = 0; SelExpMuxR = 0; SelManMuxR = 0;
  endtask

  task automatic drive_load(input logic [24:0] sum, input logic [7:0] ex, input logic [2:0] grs);
    idle_inputs();
    Load = 1; SumIn = sum; ExpIn = ex; {GuardIn, RoundIn, StickyIn} = grs;
    sb.push_back(mke(sum, ex, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic drive_op(input int op, input logic [4:0] sh, input logic inc,
                          input logic dec, input logic sele, input exp_t e);
    idle_inputs();
    SREn        = (op == 1) || (op == 4) || (op == 5);
    SLEn        = (op == 2) || (op == 5);
    NoShift     = (op == 3);
    SelManMuxR  = (op == 4);
    SelExpMuxR  = sele;
    ShiftAmount = sh;
    IncrEn      = inc;
    DecrEn      = dec;
    sb.push_back(e);
  endtask

  // Idle cycle: state holds, ResultValid must fall.
  task automatic drive_idle(input exp_t prev);
    idle_inputs();
    sb.push_back(mke(prev.out, prev.ex, 1'b0, prev.ovf, prev.unf));
  endtask

  task automatic step_check(input string tag);
    exp_t e;
    @(posedge Clock);
    #1;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, "Out", {7'd0, Out}, {7'd0, e.out});
      chk(tag, "ExpOut", {24'd0, ExpOut}, {24'd0, e.ex});
      chk(tag, "ResultMan", {9'd0, ResultMan}, {9'd0, e.out[22:0]});
      chk(tag, "ResultValid", {31'd0, ResultValid}, {31'd0, e.vld});
      chk(tag, "Overflow", {31'd0, Overflow}, {31'd0, e.ovf});
      chk(tag, "Underflow", {31'd0, Underflow}, {31'd0, e.unf});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[16];
    exp_t e;
    tbl[0]  = mk(25'h1000000, 8'd127, 3'b000, 1, 5'd0,  1, 0, 0, 25'h0800000, 8'd128, 1, 0, 0);
    tbl[1]  = mk(25'h0000100, 8'd100, 3'b000, 2, 5'd15, 0, 1, 0, 25'h0800000, 8'd85,  1, 0, 0);
    tbl[2]  = mk(25'h0FFFFFF, 8'd127, 3'b100, 3, 5'd0,  0, 0, 0, 25'h1000000, 8'd127, 0, 0, 0);
    tbl[3]  = mk(25'h0800000, 8'd127, 3'b100, 3, 5'd0,  0, 0, 0, 25'h0800000, 8'd127, 1, 0, 0);
    tbl[4]  = mk(25'h0800001, 8'd127, 3'b100, 3, 5'd0,  0, 0, 0, 25'h0800002, 8'd127, 1, 0, 0);
    tbl[5]  = mk(25'h0800001, 8'd127, 3'b101, 3, 5'd0,  0, 0, 0, 25'h0800002, 8'd127, 1, 0, 0);
    tbl[6]  = mk(25'h0800001, 8'd127, 3'b010, 3, 5'd0,  0, 0, 0, 25'h0800001, 8'd127, 1, 0, 0);
    tbl[7]  = mk(25'h1000000, 8'd254, 3'b000, 1, 5'd0,  1, 0, 0, 25'h0800000, 8'd255, 1, 1, 0);
    tbl[8]  = mk(25'h0000100, 8'd3,   3'b000, 2, 5'd15, 0, 1, 0, 25'h0800000, 8'd0,   1, 0, 1);
    tbl[9]  = mk(25'h1000000, 8'd50,  3'b000, 5, 5'd3,  1, 0, 0, 25'h0800000, 8'd51,  1, 0, 0);
    tbl[10] = mk(25'h1000000, 8'd50,  3'b000, 1, 5'd0,  1, 1, 0, 25'h0800000, 8'd50,  1, 0, 0);
    tbl[11] = mk(25'h0000003, 8'd10,  3'b100, 1, 5'd0,  0, 0, 0, 25'h0000002, 8'd10,  1, 0, 0);
    tbl[12] = mk(25'h0400000, 8'd20,  3'b110, 2, 5'd1,  0, 1, 0, 25'h0800002, 8'd19,  1, 0, 0);
    tbl[13] = mk(25'h1000000, 8'd127, 3'b000, 4, 5'd0,  1, 0, 1, 25'h0800000, 8'd128, 1, 0, 0);
    tbl[14] = mk(25'h1000000, 8'd255, 3'b000, 1, 5'd0,  1, 0, 0, 25'h0800000, 8'd255, 1, 1, 0);
    tbl[15] = mk(25'h0000100, 8'd15,  3'b000, 2, 5'd15, 0, 1, 0, 25'h0800000, 8'd0,   1, 0, 1);

    idle_inputs();
    Reset = 1;
    sb.push_back(mke('0, '0, 0, 0, 0));
    step_check("reset");
    Reset = 0;

    for (int i = 0; i < 16; i++) begin
      drive_load(tbl[i].sum, tbl[i].ex, tbl[i].grs);
      step_check($sformatf("vec%0d_load", i));
      e = mke(tbl[i].e_out, tbl[i].e_ex, tbl[i].e_vld, tbl[i].e_ovf, tbl[i].e_unf);
      drive_op(tbl[i].op, tbl[i].sh, tbl[i].inc, tbl[i].dec, tbl[i].sele, e);
      step_check($sformatf("vec%0d_op", i));
      drive_idle(e);
      step_check($sformatf("vec%0d_idle", i));
    end

    // Rounding carry then renormalize with exponent bump.
    drive_load(25'h0FFFFFF, 8'd127, 3'b100);
    step_check("renorm_load");
    drive_op(3, 5'd0, 0, 0, 0, mke(25'h1000000, 8'd127, 0, 0, 0));
    step_check("renorm_round");
    drive_op(4, 5'd0, 1, 0, 1, mke(25'h0800000, 8'd128, 1, 0, 0));
    step_check("renorm_shift");
    drive_idle(mke(25'h0800000, 8'd128, 1, 0, 0));
    step_check("renorm_idle");

    // Overflow is sticky across idle and cleared by the next Load.
    drive_load(25'h1000000, 8'd254, 3'b000);
    step_check("ovf_load");
    drive_op(1, 5'd0, 1, 0, 0, mke(25'h0800000, 8'd255, 1, 1, 0));
    step_check("ovf_op");
    drive_idle(mke(25'h0800000, 8'd255, 1, 1, 0));
    step_check("ovf_hold");
    drive_load(25'h0123456, 8'd77, 3'b000);
    step_check("ovf_clear");

    // Load wins over a simultaneous shift strobe.
    drive_load(25'h1000000, 8'd127, 3'b000);
    SREn = 1; IncrEn = 1;
    step_check("load_with_sren");

    // Reset during an SLEn cycle discards the operation.
    drive_load(25'h0000100, 8'd100, 3'b000);
    step_check("rst_load");
    drive_op(2, 5'd15, 0, 1, 0, mke('0, '0, 0, 0, 0));
    Reset = 1;
    step_check("rst_during_sle");
    Reset = 0;
    drive_idle(mke('0, '0, 0, 0, 0));
    step_check("rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
